// File: rtl/fir_tdm_multichannel.sv
// Time-multiplexed FIR filter: N_CH independent delay lines share one serial
// multiply-accumulate unit that processes one tap per clock.
module fir_tdm_multichannel #(
    parameter int N_CH = 2,
    parameter int TAPS = 16,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter logic [TAPS*CW-1:0] COEFFS = {TAPS{{{(CW-1){1'b0}}, 1'b1}}},
    parameter int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int OW   = DW + 1 + CW + $clog2(TAPS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [CHW-1:0] in_ch,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    input  logic           flush,
    output logic           out_valid,
    output logic [CHW-1:0] out_ch,
    output logic [OW-1:0]  out_data,
    output logic           err_ch
);

    localparam int KW = $clog2(TAPS);
    localparam int PW = DW + CW + 1;
    localparam logic [KW-1:0]  K_LAST   = KW'(TAPS - 1);
    localparam logic [CHW:0]   N_CH_EXT = (CHW + 1)'(N_CH);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state;
    logic [DW-1:0]          line [N_CH][TAPS];
    logic [CHW-1:0]         ch_q;
    logic [KW-1:0]          k;
    logic signed [OW-1:0]   acc;

    logic [DW-1:0]          x_sel;
    logic signed [CW-1:0]   c_sel;
    logic signed [PW-1:0]   x_ext;
    logic signed [PW-1:0]   c_ext;
    logic signed [PW-1:0]   prod;
    logic                   ch_ok;

    assign in_ready = (state == IDLE) && !flush;
    assign ch_ok    = ({1'b0, in_ch} < N_CH_EXT);

    // Samples are zero-extended to stay non-negative before the signed multiply.
    always_comb begin
        x_sel = line[ch_q][k];
        c_sel = COEFFS[int'(k)*CW +: CW];
        x_ext = PW'($signed({1'b0, x_sel}));
        c_ext = PW'(c_sel);
        prod  = x_ext * c_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch_q      <= '0;
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            err_ch    <= 1'b0;
            for (int unsigned c = 0; c < N_CH; c++)
                for (int unsigned t = 0; t < TAPS; t++)
                    line[c][t] <= '0;
        end else begin
            out_valid <= 1'b0;
            err_ch    <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int unsigned c = 0; c < N_CH; c++)
                            for (int unsigned t = 0; t < TAPS; t++)
                                line[c][t] <= '0;
                    end else if (in_valid) begin
                        if (ch_ok) begin
                            line[in_ch][0] <= in_data;
                            for (int unsigned t = 1; t < TAPS; t++)
                                line[in_ch][t] <= line[in_ch][t-1];
                            ch_q  <= in_ch;
                            acc   <= '0;
                            k     <= '0;
                            state <= MAC;
                        end else begin
                            err_ch <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc <= acc + OW'(prod);
                    if (k == K_LAST)
                        state <= OUT;
                    else
                        k <= k + 1'b1;
                end
                OUT: begin
                    out_valid <= 1'b1;
                    out_data  <= acc;
                    out_ch    <= ch_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_multichannel.sv
// Directed bench for fir_tdm_multichannel: default 2-channel/16-tap instance
// plus a 3-channel/4-tap instance with signed coefficients.
module tb_fir_tdm_multichannel;

    localparam int A_TAPS = 16;
    localparam int B_TAPS = 4;
    localparam int A_OW   = 21;
    localparam int B_OW   = 19;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic             a_in_valid = 1'b0;
    logic             a_flush    = 1'b0;
    logic [0:0]       a_in_ch    = '0;
    logic [7:0]       a_in_data  = '0;
    logic             a_in_ready, a_out_valid, a_err_ch;
    logic [0:0]       a_out_ch;
    logic [A_OW-1:0]  a_out_data;

    logic             b_in_valid = 1'b0;
    logic             b_flush    = 1'b0;
    logic [1:0]       b_in_ch    = '0;
    logic [7:0]       b_in_data  = '0;
    logic             b_in_ready, b_out_valid, b_err_ch;
    logic [1:0]       b_out_ch;
    logic [B_OW-1:0]  b_out_data;

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;

    typedef struct {
        int     ch;
        longint data;
        longint due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    fir_tdm_multichannel dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ch(a_in_ch), .in_data(a_in_data),
        .in_ready(a_in_ready), .flush(a_flush),
        .out_valid(a_out_valid), .out_ch(a_out_ch), .out_data(a_out_data),
        .err_ch(a_err_ch)
    );

    fir_tdm_multichannel #(
        .N_CH(3),
        .TAPS(B_TAPS),
        .COEFFS(32'h04FD_0201)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ch(b_in_ch), .in_data(b_in_data),
        .in_ready(b_in_ready), .flush(b_flush),
        .out_valid(b_out_valid), .out_ch(b_out_ch), .out_data(b_out_data),
        .err_ch(b_err_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? a_in_ready : b_in_ready;
    endfunction

    task automatic wait_ready(input int d);
        int n = 0;
        @(negedge clk); #1;
        while (!rdy(d) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!rdy(d)) check((d == 0) ? "a_ready_timeout" : "b_ready_timeout", rdy(d), 1);
    endtask

    // Offer one sample; the expected result is queued with its due cycle.
    task automatic send(input int d, input int ch, input int data, input longint exp_v);
        exp_t e;
        wait_ready(d);
        if (d == 0) begin
            a_in_valid = 1'b1; a_in_ch = 1'(ch); a_in_data = 8'(data);
        end else begin
            b_in_valid = 1'b1; b_in_ch = 2'(ch); b_in_data = 8'(data);
        end
        e.ch   = ch;
        e.data = exp_v;
        e.due  = cyc + 1 + ((d == 0) ? A_TAPS : B_TAPS) + 1;
        if (rdy(d)) begin
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    // Flush in IDLE with a competing sample that must be ignored.
    task automatic flush_idle_a();
        wait_ready(0);
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_ch = 1'b0; a_in_data = 8'd99;
        #1;
        check("a_in_ready_during_flush", a_in_ready, 0);
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
    endtask

    task automatic bad_ch_b();
        wait_ready(1);
        b_in_valid = 1'b1; b_in_ch = 2'd3; b_in_data = 8'd9;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("b_err_ch_pulse", b_err_ch, 1);
        check("b_in_ready_after_err", b_in_ready, 1);
        @(posedge clk); #1;
        check("b_err_ch_single", b_err_ch, 0);
    endtask

    task automatic hold_valid_a();
        exp_t   e;
        int     n = 0;
        int     guard = 0;
        longint last = 0;
        a_in_valid = 1'b1; a_in_ch = 1'b0; a_in_data = 8'd7;
        while (n < 5 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
            if (a_in_ready) begin
                n++;
                e.ch = 0; e.data = 7 * n; e.due = cyc + 1 + A_TAPS + 1;
                qa.push_back(e);
                if (n > 1) check("a_accept_spacing", cyc + 1 - last, A_TAPS + 2);
                last = cyc + 1;
            end
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("a_handshake_accepts", n, 5);
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0 && cyc == qa[0].due) begin
            ea = qa.pop_front();
            check("a_out_valid", a_out_valid, 1);
            check("a_out_ch", a_out_ch, ea.ch);
            check("a_out_data", $signed(a_out_data), ea.data);
        end else if (a_out_valid) begin
            check("a_out_valid_spurious", a_out_valid, 0);
        end
    end

    always @(negedge clk) begin
        if (qb.size() > 0 && cyc == qb[0].due) begin
            eb = qb.pop_front();
            check("b_out_valid", b_out_valid, 1);
            check("b_out_ch", b_out_ch, eb.ch);
            check("b_out_data", $signed(b_out_data), eb.data);
        end else if (b_out_valid) begin
            check("b_out_valid_spurious", b_out_valid, 0);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_out_ch", a_out_ch, 0);
        check("rst_a_err_ch", a_err_ch, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_in_ready", b_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Step response: 255*n, saturating at 4080.
        for (int n = 1; n <= 18; n++)
            send(0, 0, 255, 255 * ((n < 16) ? n : 16));

        flush_idle_a();
        send(0, 0, 50, 50);

        // Interleaved channels settle independently.
        flush_idle_a();
        for (int n = 1; n <= 18; n++) begin
            send(0, 0, 10, 10 * ((n < 16) ? n : 16));
            send(0, 1, 200, 200 * ((n < 16) ? n : 16));
        end

        // Reset mid-MAC abandons the computation and clears the lines.
        send(0, 0, 100, 100);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check("midrst_a_out_valid", a_out_valid, 0);
        check("midrst_a_out_data", a_out_data, 0);
        check("midrst_a_out_ch", a_out_ch, 0);
        check("midrst_a_err_ch", a_err_ch, 0);
        check("midrst_a_in_ready", a_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 0, 100, 100);

        // Flush during MAC is ignored; the lines keep their contents.
        send(0, 0, 30, 130);
        @(negedge clk);
        a_flush = 1'b1;
        #1;
        check("a_in_ready_mac", a_in_ready, 0);
        repeat (3) @(negedge clk);
        a_flush = 1'b0;
        send(0, 0, 0, 130);

        flush_idle_a();
        hold_valid_a();

        // Impulse through coefficients {4,-3,2,1}.
        send(1, 1, 1, 1);
        send(1, 1, 0, 2);
        send(1, 1, 0, -3);
        send(1, 1, 0, 4);
        send(1, 1, 0, 0);

        // Out-of-range channel leaves the lines untouched.
        send(1, 0, 5, 5);
        bad_ch_b();
        send(1, 0, 0, 10);

        repeat (40) @(negedge clk);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
